// File: rtl/multdiv_pkg.sv
// Shared types and latencies for the mul/div writeback scoreboard.
package multdiv_pkg;

  localparam int unsigned MUL_LAT = 16;
  localparam int unsigned DIV_LAT = 32;
  localparam int unsigned NREG    = 32;
  localparam int unsigned RW      = 5;
  localparam int unsigned CNT_W   = $clog2(DIV_LAT);

  typedef enum logic [0:0] {
    D_IDLE = 1'b0,
    D_BUSY = 1'b1
  } div_state_e;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
  } inflight_t;

endpackage

// File: rtl/md_inflight_pipe.sv
// Fixed-latency tracker for pipelined muls: one entry enters per cycle and
// emerges at the tail exactly MUL_LAT cycles after acceptance.
module md_inflight_pipe
  import multdiv_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  inflight_t push_i,
  output inflight_t tail_o,
  output logic      any_valid_o
);

  inflight_t [MUL_LAT-1:0] stages_q;
  inflight_t [MUL_LAT-1:0] stages_d;

  // Shift by one stage per cycle; new entry lands in stage 0.
  always_comb begin
    stages_d = {stages_q[MUL_LAT-2:0], push_i};
  end

  // Any entry still travelling, tail included.
  always_comb begin
    any_valid_o = 1'b0;
    for (int unsigned i = 0; i < MUL_LAT; i++) begin
      any_valid_o = any_valid_o | stages_q[i].valid;
    end
  end

  assign tail_o = stages_q[MUL_LAT-1];

  // Stage registers; reset kills every in-flight entry.
  always_ff @(posedge clock) begin
    if (reset) stages_q <= '0;
    else       stages_q <= stages_d;
  end

endmodule

// File: rtl/multdiv_scoreboard.sv
// Issue/hazard scoreboard for a pipelined multiplier and an iterative divider
// sharing one regfile write port. Define MULTDIV_DIV_EN to build the divider;
// without it every div request is refused and only muls are tracked.
module multdiv_scoreboard
  import multdiv_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic          issue_is_div,
  input  logic [RW-1:0] issue_rd,
  output logic          issue_ready,
  input  logic          src_valid,
  input  logic [RW-1:0] src1,
  input  logic [RW-1:0] src2,
  output logic          raw_stall,
  output logic          md_wb_valid,
  output logic [RW-1:0] md_wb_rd,
  output logic          hold_mw,
  output logic [NREG-1:0] pending,
  output logic          exc_pending
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  inflight_t       mul_push;
  inflight_t       mul_tail;
  logic            mul_any;
  logic            div_busy;
  logic            div_wb;
  logic            div_coll;
  logic [RW-1:0]   div_rd;
  logic            div_ok;
  logic            waw;
  logic            accept;
  logic            mul_wb;
  logic            wb_any;
  logic [RW-1:0]   wb_rd;

  md_inflight_pipe u_mul_pipe (
    .clock       (clock),
    .reset       (reset),
    .push_i      (mul_push),
    .tail_o      (mul_tail),
    .any_valid_o (mul_any)
  );

`ifdef MULTDIV_DIV_EN
  div_state_e       state_q;
  div_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [RW-1:0]    div_rd_q;
  logic [RW-1:0]    div_rd_d;

  // Divider FSM: load on accepted div, count down, write back at zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_rd_d = div_rd_q;
    unique case (state_q)
      D_IDLE: begin
        if (accept && issue_is_div) begin
          state_d  = D_BUSY;
          cnt_d    = CNT_W'(DIV_LAT - 1);
          div_rd_d = issue_rd;
        end
      end
      D_BUSY: begin
        if (cnt_q == '0) state_d = D_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = D_IDLE;
    endcase
  end

  // Divider state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= D_IDLE;
      cnt_q    <= '0;
      div_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_rd_q <= div_rd_d;
    end
  end

  assign div_busy = (state_q == D_BUSY);
  assign div_wb   = div_busy && (cnt_q == '0);
  // A mul issued now would land on the same cycle as the div result.
  assign div_coll = div_busy && (cnt_q == CNT_W'(MUL_LAT));
  assign div_rd   = div_rd_q;
  assign div_ok   = !div_busy && !mul_any;
`else
  assign div_busy = 1'b0;
  assign div_wb   = 1'b0;
  assign div_coll = 1'b0;
  assign div_rd   = '0;
  assign div_ok   = 1'b0;
`endif

  // Issue acceptance: WAW, divider occupancy and writeback-port collision.
  always_comb begin
    waw         = (issue_rd != '0) && pending_q[issue_rd];
    issue_ready = !reset && !waw && (issue_is_div ? div_ok : !div_coll);
    accept      = issue_valid && issue_ready;
    mul_push    = '0;
    if (accept && !issue_is_div) begin
      mul_push.valid = 1'b1;
      mul_push.rd    = issue_rd;
    end
  end

  // Writeback select; the issue rules guarantee mul and div never coincide.
  always_comb begin
    mul_wb      = mul_tail.valid && (mul_tail.rd != '0);
    wb_any      = mul_wb || (div_wb && (div_rd != '0));
    wb_rd       = mul_wb ? mul_tail.rd : div_rd;
    md_wb_valid = !reset && wb_any;
    md_wb_rd    = md_wb_valid ? wb_rd : '0;
    hold_mw     = md_wb_valid;
  end

  // Pending bits: set on accept, clear on writeback, r0 never tracked.
  always_comb begin
    pending_d = pending_q;
    if (accept && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
    if (wb_any)                     pending_d[wb_rd]    = 1'b0;
    pending_d[0] = 1'b0;
  end

  // Pending register.
  always_ff @(posedge clock) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  // Hazard and status outputs, all forced quiet while reset is held.
  always_comb begin
    pending     = reset ? '0 : pending_q;
    raw_stall   = !reset && src_valid &&
                  (((src1 != '0) && pending_q[src1]) ||
                   ((src2 != '0) && pending_q[src2]));
    exc_pending = !reset && ((|pending_q) || mul_any || div_busy);
  end

endmodule

// File: tb/tb_multdiv_scoreboard.sv
// Directed bench for multdiv_scoreboard with a per-cycle reference model.
module tb_multdiv_scoreboard;

  localparam int ML = 16;
  localparam int DL = 32;
`ifdef MULTDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_is_div = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_ready;
  logic        src_valid = 1'b0;
  logic [4:0]  src1 = '0;
  logic [4:0]  src2 = '0;
  logic        raw_stall;
  logic        md_wb_valid;
  logic [4:0]  md_wb_rd;
  logic        hold_mw;
  logic [31:0] pending;
  logic        exc_pending;

  int n_checks = 0;
  int n_pass   = 0;

  multdiv_scoreboard dut (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_is_div (issue_is_div),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .src_valid    (src_valid),
    .src1         (src1),
    .src2         (src2),
    .raw_stall    (raw_stall),
    .md_wb_valid  (md_wb_valid),
    .md_wb_rd     (md_wb_rd),
    .hold_mw      (hold_mw),
    .pending      (pending),
    .exc_pending  (exc_pending)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         a;
    int         d;
    logic [4:0] rd;
    bit         dv;
  } op_t;

  op_t         ops[$];
  op_t         nop;
  int          cyc = 0;
  logic [31:0] e_pend;
  bit          e_exc, e_busy, e_mfl, e_coll, e_wb, e_rdy, e_raw;
  logic [4:0]  e_wbrd;

  always @(negedge clock) begin
    e_pend = '0; e_exc = 0; e_busy = 0; e_mfl = 0; e_coll = 0; e_wb = 0; e_wbrd = '0;
    foreach (ops[i]) begin
      if (ops[i].a < cyc && cyc <= ops[i].d) begin
        e_exc = 1;
        if (ops[i].rd != 0) e_pend[ops[i].rd] = 1'b1;
        if (ops[i].dv) begin
          e_busy = 1;
          if (ops[i].d - cyc == ML) e_coll = 1;
        end else begin
          e_mfl = 1;
        end
        if (ops[i].d == cyc && ops[i].rd != 0) begin
          e_wb = 1; e_wbrd = ops[i].rd;
        end
      end
    end
    if (reset) begin
      e_pend = '0; e_exc = 0; e_busy = 0; e_mfl = 0; e_coll = 0; e_wb = 0; e_wbrd = '0;
    end
    e_rdy = !reset && !(issue_rd != 0 && e_pend[issue_rd]) &&
            (issue_is_div ? (DIV_EN && !e_busy && !e_mfl) : !e_coll);
    e_raw = !reset && src_valid &&
            ((src1 != 0 && e_pend[src1]) || (src2 != 0 && e_pend[src2]));
    check("m_ready",   issue_ready, e_rdy);
    check("m_raw",     raw_stall,   e_raw);
    check("m_wbv",     md_wb_valid, e_wb);
    check("m_wbrd",    md_wb_rd,    e_wbrd);
    check("m_hold",    hold_mw,     e_wb);
    check("m_pending", pending,     e_pend);
    check("m_exc",     exc_pending, e_exc);
    if (reset) ops.delete();
    else if (issue_valid && e_rdy) begin
      nop.a = cyc; nop.d = cyc + (issue_is_div ? DL : ML); nop.rd = issue_rd; nop.dv = issue_is_div;
      ops.push_back(nop);
    end
    for (int i = ops.size() - 1; i >= 0; i--) if (ops[i].d <= cyc) ops.delete(i);
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  task automatic nxt(); @(posedge clock); #1; endtask
  task automatic neg(); @(negedge clock); endtask
  task automatic issue(input bit dv, input logic [4:0] rd);
    issue_valid = 1'b1; issue_is_div = dv; issue_rd = rd;
  endtask
  task automatic idle();
    issue_valid = 1'b0; issue_is_div = 1'b0; issue_rd = '0;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    neg();
    check("rst_pending", pending, 32'h0);
    check("rst_exc", exc_pending, 0);
    check("rst_wb", md_wb_valid, 0);
    nxt();

    // mul rd=5: pending cycles 1..16, writeback at 16
    issue(0, 5'd5); neg(); check("a_ready", issue_ready, 1); nxt(); idle();
    for (int c = 1; c <= 16; c++) begin
      neg();
      check("a_pend5", pending[5], 1);
      if (c == 16) begin
        check("a_wbv", md_wb_valid, 1); check("a_wbrd", md_wb_rd, 5); check("a_hold", hold_mw, 1);
      end else check("a_nowb", md_wb_valid, 0);
      nxt();
    end
    neg(); check("a_clr", pending[5], 0); check("a_wbv0", md_wb_valid, 0); check("a_exc0", exc_pending, 0); nxt();

    // RAW on src1 through writeback cycle inclusive
    issue(0, 5'd7); src_valid = 1'b1; src1 = 5'd7; src2 = 5'd0;
    neg(); check("b_raw0", raw_stall, 0); nxt(); idle();
    for (int c = 1; c <= 16; c++) begin neg(); check("b_raw1", raw_stall, 1); nxt(); end
    neg(); check("b_raw_end", raw_stall, 0); nxt();
    src_valid = 1'b0; src1 = '0;

    // WAW refusal, then rd=0 accepted with silent completion
    issue(0, 5'd4); neg(); check("c_ready4", issue_ready, 1); nxt();
    issue(0, 5'd4); neg(); check("c_waw", issue_ready, 0); nxt();
    issue(0, 5'd0); neg(); check("c_ready0", issue_ready, 1); nxt(); idle();
    repeat (13) nxt();
    neg(); check("c_wb4", md_wb_valid, 1); check("c_wbrd4", md_wb_rd, 4); nxt();
    neg(); check("c_exc_r0", exc_pending, 1); check("c_pend0", pending, 32'h0); nxt();
    neg(); check("c_nowb_r0", md_wb_valid, 0); check("c_wbrd_r0", md_wb_rd, 0); nxt();
    neg(); check("c_exc_done", exc_pending, 0); nxt();

    // src2 RAW and same-cycle set/clear of different registers
    issue(0, 5'd9); nxt(); idle();
    src_valid = 1'b1; src1 = 5'd0; src2 = 5'd9;
    neg(); check("d_raw_src2", raw_stall, 1); nxt();
    src_valid = 1'b0; src2 = '0;
    repeat (14) nxt();
    issue(0, 5'd10);
    neg(); check("d_ready", issue_ready, 1); check("d_wb9", md_wb_rd, 9); nxt(); idle();
    neg(); check("d_swap", pending, 32'h0000_0400); nxt();
    repeat (17) nxt();

    // back-to-back muls write back on consecutive cycles
    issue(0, 5'd1); nxt(); issue(0, 5'd2); nxt(); issue(0, 5'd3); nxt(); idle();
    repeat (13) nxt();
    for (int k = 1; k <= 3; k++) begin
      neg(); check("e_wbv", md_wb_valid, 1); check("e_wbrd", md_wb_rd, k); nxt();
    end
    repeat (3) nxt();

`ifdef MULTDIV_DIV_EN
    // div rd=3, mul blocked at remaining==16, div writeback at 32
    issue(1, 5'd3); neg(); check("f_div_ready", issue_ready, 1); nxt(); idle();
    repeat (15) nxt();
    issue(0, 5'd8); neg(); check("f_coll", issue_ready, 0); nxt();
    neg(); check("f_mul_ok", issue_ready, 1); nxt();
    issue(1, 5'd11); neg(); check("f_div_busy", issue_ready, 0); nxt(); idle();
    repeat (13) nxt();
    neg(); check("f_div_wb", md_wb_valid, 1); check("f_div_rd", md_wb_rd, 3); nxt();
    issue(1, 5'd12); neg(); check("f_mul_wb", md_wb_rd, 8); check("f_div_mulfl", issue_ready, 0); nxt(); idle();
    neg(); check("f_exc0", exc_pending, 0); nxt();

    // reset mid-div kills the op
    issue(1, 5'd6); nxt(); idle();
    repeat (9) nxt();
    reset = 1'b1;
    neg(); check("g_pend", pending, 32'h0); check("g_exc", exc_pending, 0); check("g_wb", md_wb_valid, 0); nxt();
    reset = 1'b0;
    neg(); check("g_exc_after", exc_pending, 0);
    for (int c = 11; c <= 40; c++) begin
      if (c > 11) neg();
      check("g_nowb", md_wb_valid, 0);
      nxt();
    end
`else
    // divider absent: div refused, nothing recorded
    issue(1, 5'd12); neg(); check("h_div_refused", issue_ready, 0); nxt(); idle();
    neg(); check("h_pend", pending, 32'h0); check("h_exc", exc_pending, 0); nxt();
`endif

    repeat (3) nxt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multdiv_scoreboard.md
MULTDIV_SCOREBOARD -- requirements
Module: multdiv_scoreboard

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; every state element updates on its rising edge.
REQ-002 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port issue_valid, input, 1, D/X presents a mul/div for issue.
REQ-004 SHALL have port issue_is_div, input, 1, 1=div, 0=mul.
REQ-005 SHALL have port issue_rd, input, 5, destination register.
REQ-006 SHALL have port issue_ready, output, 1, issue accepted this cycle when issue_valid & issue_ready.
REQ-007 SHALL have ports src_valid (input, 1), src1 (input, 5) and src2 (input, 5): the source registers of the instruction in D.
REQ-008 SHALL have port raw_stall, output, 1, hold PC/F.D/D.X.
REQ-009 SHALL have ports md_wb_valid (output, 1) and md_wb_rd (output, 5): multdiv result writes the regfile this cycle.
REQ-010 SHALL have port hold_mw, output, 1, M.W latch holds; main pipeline yields the regfile write port.
REQ-011 SHALL have port pending, output, 32, one bit per register with a write outstanding.
REQ-012 SHALL have port exc_pending, output, 1, any op in flight; bex waits on it.

Function
REQ-013 SHALL complete a mul issued at cycle t with md_wb_valid=1 at exactly t+MUL_LAT (MUL_LAT=16); muls are pipelined and one may issue per cycle.
REQ-014 SHALL complete a div issued at cycle t at exactly t+DIV_LAT (DIV_LAT=32); the divider is iterative and holds one div at a time.
REQ-015 SHALL run divider FSM D_IDLE -> D_BUSY on div issue; in D_BUSY, count DIV_LAT-1 down to 0; at count 0 assert writeback and return to D_IDLE; no other transitions.
REQ-016 SHALL drive issue_ready=0 when: issue_rd!=0 and pending[issue_rd]=1 (WAW); or a div is requested while in D_BUSY; or a div is requested while any mul is in flight; or a mul is requested while div remaining count==MUL_LAT (writeback collision).
REQ-017 SHALL set pending[issue_rd] on the edge ending the accept cycle and clear it on the edge ending its md_wb_valid cycle; pending[0] SHALL be constant 0.
REQ-018 SHALL accept issue_rd=0 normally, but its completion SHALL produce md_wb_valid=0, with no pending change.
REQ-019 SHALL drive raw_stall = src_valid & ((src1!=0 & pending[src1]) | (src2!=0 & pending[src2])), combinationally, including during the writeback cycle.
REQ-020 SHALL apply a same-cycle issue of rd A and completion of rd B (A!=B) as both set A and clear B.
REQ-021 SHALL drive hold_mw equal to md_wb_valid.
REQ-022 SHALL drive exc_pending as the OR of pending, the mul in-flight valids and D_BUSY.
REQ-023 SHALL make issue_ready, raw_stall, hold_mw and md_wb_rd combinational; md_wb_rd SHALL be 0 when md_wb_valid=0.

Reset
REQ-024 SHALL, while reset=1 (including mid-operation), clear all in-flight mul entries, force the divider to D_IDLE with count 0 and pending to 0, and drive md_wb_valid=0, hold_mw=0, exc_pending=0 and raw_stall=0; no writeback from a killed op SHALL ever occur.

Configuration
REQ-025 SHALL, with MULTDIV_DIV_EN defined, include the divider FSM and div issue; without it, the divider logic SHALL be absent, issue_ready SHALL be 0 for any div request and behave identically to the defined case for mul.

Structure
REQ-026 SHALL place MUL_LAT, DIV_LAT, the divider state encoding and the in-flight entry type {valid, rd[4:0]} in shared package multdiv_pkg.
REQ-027 SHALL implement the mul in-flight tracker as sub-module md_inflight_pipe, a MUL_LAT-deep shift register of entries that outputs the tail entry.

Verification
REQ-028 SHALL cover: mul rd=5 at cycle 0 -> pending[5]=1 during cycles 1..16; md_wb_valid=1, md_wb_rd=5 and hold_mw=1 at cycle 16; pending[5]=0 from cycle 17.
REQ-029 SHALL cover: mul rd=7 in flight, src1=7, src_valid=1 -> raw_stall=1 until the writeback cycle inclusive, then 0.
REQ-030 SHALL cover: div rd=3 at cycle 0, then mul at cycle 16 (remaining count==16) -> issue_ready=0 at 16 and 1 at 17; div writeback at cycle 32.
REQ-031 SHALL cover: mul rd=4 pending, second mul rd=4 -> issue_ready=0; mul rd=0 -> accepted, no writeback 16 cycles later.
REQ-032 SHALL cover: reset=1 at cycle 10 of a div -> pending=0, exc_pending=0, and no md_wb_valid through cycle 40.
REQ-033 SHALL cover: MULTDIV_DIV_EN undefined, div request -> issue_ready=0 and pending unchanged.
